bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Parametrised, registered replacement for the fixed four-source priority bus mux in the SAP-U top level.
- Arbitrates N active-low bus-enable requests, drives one WIDTH-bit shared bus, and supports fixed-priority or round-robin mode.
- Holds the last driven value when the bus is idle, instead of emitting Z.
- Detects and counts multi-driver contention for debug and for the future control unit.

Parameters:
- N, 4, number of bus sources (2..16).
- WIDTH, 8, bus data width.
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- src_data  in  N*WIDTH  source data, concatenated; source i occupies bits [i*WIDTH +: WIDTH].
- src_enable_n  in  N  active-low bus-enable request per source.
- mode_rr  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- clear_contention  in  1  synchronous clear of the contention flag and counter.
- bus_out  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_out was driven by a grant this cycle.
- grant  out  N  registered one-hot grant; all zero when idle.
- grant_idx  out  $clog2(N)  index of the granted source; holds its last value when idle.
- contention  out  1  sticky flag: more than one enable was asserted in some cycle.
- contention_count  out  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (asynchronous, active-high) forces bus_out=0, bus_valid=0, grant=0, grant_idx=0, internal rr pointer=0, contention=0, contention_count=0. It takes effect immediately, including mid-burst.
- req[i] = ~src_enable_n[i]. Arbitration is evaluated each cycle; all outputs are registered with 1-cycle latency (inputs at edge k appear at edge k+1).
- Fixed-priority mode: the lowest-index asserted request wins.
- Round-robin mode: search starts at the rr pointer and wraps modulo N; the first asserted request wins.
  - Parking: if the current grantee still requests, it keeps the grant, and the pointer does not move.
  - When a new grant is issued to source g, the pointer becomes (g+1) mod N, wrapping from N-1 to 0.
- Fixed-priority mode ignores the pointer but preserves it.
- A mode_rr change takes effect at the next arbitration edge. No flush is performed, and a parked grant is re-evaluated under the new mode.
- When a grant is issued: bus_out <= src_data[g], bus_valid <= 1, grant <= 1<<g, grant_idx <= g.
- When no request is asserted: bus_out holds its previous value, bus_valid <= 0, grant <= 0, grant_idx holds, and parking is released.
- Contention: when popcount(req) >= 2 in a cycle, contention <= 1 (sticky) and contention_count increments, saturating at 2^CNT_W-1.
  - Arbitration still picks exactly one winner; contention never blocks the bus.
- clear_contention sets contention <= 0 and contention_count <= 0.
  - If clear_contention and a new contention occur in the same cycle, contention <= 1 and contention_count <= 1.
- Single request: no contention. grant is always one-hot or zero, never multi-hot.

Decomposition:
- Shared package sap_bus_pkg holds:
  - the default widths (SAP_BUS_WIDTH=8, SAP_BUS_SOURCES=4);
  - localparam source indices (SRC_REG_A=0, SRC_REG_B=1, SRC_RAM=2, SRC_ALU=3);
  - the arbitration-mode encoding constants.
- One sub-module, rr_picker: a combinational rotate-priority-rotate-back find-first-set, taking req and a start pointer and returning a one-hot result and an index. It is reused for fixed mode with the pointer forced to 0.

Test Plan (N=4, WIDTH=8, CNT_W=8):
- Reset, then set only src_enable_n[1]=0 with src1=0x5A -> next edge: bus_out=0x5A, bus_valid=1, grant=0010, grant_idx=1, contention=0.
- Fixed mode, sources 0 and 3 both requesting with values 0x11 and 0x33 -> bus_out=0x11, grant=0001, contention=1, count=1; repeat for 3 cycles -> count=4.
- RR mode, all four sources pulse one cycle each on alternate cycles -> grants 0,1,2,3,0; one source holding its request continuously keeps the grant (parking) while the others also request.
- Pointer at 3, then sources 0 and 3 request -> 3 wins and the pointer wraps to 0. Next all-request cycle after idle -> 0 wins.
- Drive 0xC3, then release all enables -> bus_out stays 0xC3, bus_valid=0, grant=0000, grant_idx unchanged.
- Force 260 contention cycles -> count saturates at 255. Assert clear_contention during a contention cycle -> contention=1, count=1. Assert reset asynchronously mid-grant -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/sap_bus_pkg.sv
// Shared constants for the SAP-U bus: default widths, source slot indices
// and the arbitration-mode encoding used by the bus arbiter.
package sap_bus_pkg;

  localparam int SAP_BUS_WIDTH   = 8;
  localparam int SAP_BUS_SOURCES = 4;

  // Source slots of the legacy four-way bus, in default priority order.
  localparam int SRC_REG_A = 0;
  localparam int SRC_REG_B = 1;
  localparam int SRC_RAM   = 2;
  localparam int SRC_ALU   = 3;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus-side signal bundle of the arbiter: source requests/data in, registered
// bus, grant and contention debug state out.
interface bus_arbiter_if
  import sap_bus_pkg::*;
#(
  parameter int N     = SAP_BUS_SOURCES,
  parameter int WIDTH = SAP_BUS_WIDTH,
  parameter int CNT_W = 8
);

  localparam int IDX_W = $clog2(N);

  logic [N*WIDTH-1:0] src_data;
  logic [N-1:0]       src_enable_n;
  logic               mode_rr;
  logic               clear_contention;

  logic [WIDTH-1:0]   bus_out;
  logic               bus_valid;
  logic [N-1:0]       grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               contention;
  logic [CNT_W-1:0]   contention_count;

  // The sources and the control unit drive requests and observe the bus.
  modport master (
    output src_data, src_enable_n, mode_rr, clear_contention,
    input  bus_out, bus_valid, grant, grant_idx, contention, contention_count
  );

  modport slave (
    input  src_data, src_enable_n, mode_rr, clear_contention,
    output bus_out, bus_valid, grant, grant_idx, contention, contention_count
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational rotating find-first-set: the first asserted request at or
// after 'start' (wrapping modulo N) wins; start=0 gives plain lowest-index priority.
module rr_picker #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0]   doubled;
  logic [N-1:0]     rotated;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W:0]   sum;

  // Rotating right by 'start' puts the search origin at bit 0.
  assign doubled = {req, req};
  assign rotated = doubled[start +: N];
  assign any     = |req;

  always_comb begin
    // NOTE: assign every always_comb output a default before any branch,
    // otherwise paths that skip the assignment infer a latch.
    rot_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) rot_idx = IDX_W'(i);
    end
  end

  // Rotate back: add the origin and wrap modulo N (N need not be a power of 2).
  assign sum = {1'b0, rot_idx} + {1'b0, start};

  always_comb begin
    idx = sum[IDX_W-1:0];
    if (sum >= (IDX_W + 1)'(N)) idx = IDX_W'(sum - (IDX_W + 1)'(N));
  end

  assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Registered N-source bus arbiter with fixed-priority or parking round-robin
// selection, idle hold of the last bus value and sticky contention counting.
module bus_arbiter
  import sap_bus_pkg::*;
#(
  parameter int N     = SAP_BUS_SOURCES,
  parameter int WIDTH = SAP_BUS_WIDTH,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave bus
);

  localparam int               IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N-1:0]     req;
  logic [WIDTH-1:0] src_words [N];
  arb_mode_e        mode;

  logic [IDX_W-1:0] start_ptr;
  logic [N-1:0]     pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             parked;
  logic             multi_req;

  logic [WIDTH-1:0] bus_q,    bus_d;
  logic             valid_q,  valid_d;
  logic [N-1:0]     grant_q,  grant_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cont_q,   cont_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  assign req  = ~bus.src_enable_n;
  assign mode = arb_mode_e'(bus.mode_rr);

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign src_words[i] = bus.src_data[i*WIDTH +: WIDTH];
  end

  // Fixed priority reuses the rotating picker with the origin pinned at 0,
  // leaving the round-robin pointer untouched.
  assign start_ptr = (mode == ARB_RR) ? rr_ptr_q : '0;

  rr_picker #(.N(N)) u_picker (
    .req    (req),
    .start  (start_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // The current owner keeps the bus in round-robin mode while it still asks.
  assign parked = (mode == ARB_RR) && valid_q && req[idx_q];

  // Two or more set bits: clearing the lowest one leaves something behind.
  assign multi_req = |(req & (req - N'(1)));

  always_comb begin
    bus_d    = bus_q;
    valid_d  = 1'b0;
    grant_d  = '0;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    if (parked) begin
      valid_d = 1'b1;
      grant_d = grant_q;
      bus_d   = src_words[idx_q];
    end else if (pick_any) begin
      valid_d = 1'b1;
      grant_d = pick_onehot;
      idx_d   = pick_idx;
      bus_d   = src_words[pick_idx];
      if (mode == ARB_RR) rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  // A clear in a contention cycle restarts the count at this cycle's event.
  always_comb begin
    cont_d = cont_q;
    cnt_d  = cnt_q;
    if (bus.clear_contention) begin
      cont_d = multi_req;
      cnt_d  = multi_req ? CNT_W'(1) : '0;
    end else if (multi_req) begin
      cont_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q    <= '0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      cont_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      cont_q   <= cont_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.bus_out          = bus_q;
  assign bus.bus_valid        = valid_q;
  assign bus.grant            = grant_q;
  assign bus.grant_idx        = idx_q;
  assign bus.contention       = cont_q;
  assign bus.contention_count = cnt_q;

endmodule
